xalu_nibble_seq: RTL and testbench
==================================

Name: xalu_nibble_seq

Overview:
- Nibble-serial word sequencer placed directly upstream of the 4-bit ALU slice. It also consumes the slice's outputs.
- Accepts one word-wide operation through a valid/ready handshake and drives one operand nibble pair per cycle into the combinational slice.
- Chains carries between cycles, assembles the word result and word-level flags, then presents them through an output valid/ready handshake.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per word (legal range 1..8); W = 4*NIBBLES.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid and in_ready are both high at the clk edge.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_func  in  3  slice function code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL.
- in_com  in  1  complement-output mode.
- in_cin  in  1  word carry/shift-in.
- alu_a  out  4  A nibble to slice.
- alu_b  out  4  B nibble to slice.
- alu_f  out  3  function code to slice.
- alu_com  out  1  complement mode to slice.
- alu_ci_right  out  1  slice right carry-in.
- alu_ci_left  out  1  slice left carry-in.
- alu_d  in  4  slice result nibble.
- alu_co_left  in  1  slice left carry-out.
- alu_co_right  in  1  slice right carry-out.
- alu_equ  in  1  slice A=B.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid and out_ready are both high.
- out_res  out  W  word result.
- out_cout  out  1  word carry/shift-out.
- out_zero  out  1  out_res == 0.
- out_negzero  out  1  out_res == all ones.
- out_equ  out  1  in_a == in_b.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1 and all alu_* outputs drive 0.
  - On accept, register a, b, func, com and cin, clear the result register, set nibble counter cnt=0 and equ_acc=1, then go to RUN.
- RUN:
  - in_ready=0 for NIBBLES cycles.
  - Nibble index is cnt for func 0-5 and 7 (LSB first), and NIBBLES-1-cnt for SHR (MSB first).
  - alu_a and alu_b carry the indexed nibbles of the registered operands. alu_f=func and alu_com=com throughout.
  - Carry chain for func 0-5 and 7:
    - alu_ci_right = cin on the first step, else the registered alu_co_left of the previous step.
    - alu_ci_left = 0.
  - Carry chain for SHR:
    - alu_ci_left = cin on the first step, else the registered alu_co_right of the previous step.
    - alu_ci_right = 0.
  - At each RUN edge:
    - alu_d is written into the indexed result nibble.
    - equ_acc &= alu_equ.
    - The carry register captures (co_left for non-SHR, co_right for SHR).
    - cnt increments.
  - After step NIBBLES-1, go to DONE.
- DONE:
  - out_valid=1 and in_ready=0.
  - out_res holds the assembled result.
  - out_cout = the last captured carry, which is 0 for AND, OR, XOR, PASSA and PASSB.
  - out_zero and out_negzero are computed from out_res, and out_equ=equ_acc.
  - All outputs stay stable until out_ready=1; that edge returns the FSM to IDLE.
- Latency: accept at edge k, out_valid high from the cycle after edge k+NIBBLES.
- Throughput: one operation per NIBBLES+2 cycles minimum. No overlap is allowed, because in_ready is low outside IDLE.
- Result and flag registers hold their last values in IDLE, but out_valid=0.
- Reset, applied in any state including mid-RUN:
  - Next state IDLE with in_ready=1 after the edge.
  - out_valid=0; out_res, out_cout, out_zero, out_negzero, out_equ, cnt and the carry register all clear to 0.
  - Any in-flight operation is discarded with no output.
- in_valid while not in IDLE is ignored. out_ready while out_valid=0 is ignored.
- in_valid and out_ready both high in DONE: the request is not accepted (the FSM goes to IDLE first).
- NIBBLES=1: a single RUN cycle; the first-step carry rules apply.
- Carry arithmetic is modulo 2^W. There is no overflow flag.

Test Plan (NIBBLES=4):
- ADD: a=0x00FF, b=0x0001, cin=0, com=0 -> out_res=0x0100, cout=0, zero=0, equ=0. out_valid rises exactly 5 cycles after the accept edge. alu_a sequence is F,F,0,0.
- ADD wrap: a=0xFFFF, b=0x0001, cin=0 -> out_res=0x0000, cout=1, zero=1, negzero=0.
- Shifts: SHL a=0x8001, cin=1 -> 0x0003, cout=1. SHR a=0x8001, cin=0 -> 0x4000, cout=1, with alu_a sequence 8,0,0,1 (MSB first).
- XOR with complement: a=b=0x1234, com=1 -> out_res=0xFFFF, negzero=1, zero=0, equ=1, cout=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid and pulse in_valid meanwhile -> outputs stable, in_ready=0, second request not accepted. Releasing out_ready gives IDLE next cycle, and then a new accept.
- Reset mid-RUN: assert rst at step 2 -> next cycle state IDLE, in_ready=1, out_valid=0, out_res=0, alu_* outputs 0. A following ADD 0x0001+0x0001 returns 0x0002.

Source files
------------

// File: rtl/xalu_nibble_seq_if.sv
// Bundle of the request, slice and result signals shared by the nibble sequencer
// and its environment. The slave side is the sequencer.
interface xalu_nibble_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  // request handshake
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_func;
  logic         in_com;
  logic         in_cin;

  // 4-bit slice, driven side
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [2:0]   alu_f;
  logic         alu_com;
  logic         alu_ci_right;
  logic         alu_ci_left;

  // 4-bit slice, returned side
  logic [3:0]   alu_d;
  logic         alu_co_left;
  logic         alu_co_right;
  logic         alu_equ;

  // result handshake
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_cout;
  logic         out_zero;
  logic         out_negzero;
  logic         out_equ;

  modport slave (
    input  in_valid, in_a, in_b, in_func, in_com, in_cin,
    output in_ready,
    output alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left,
    input  alu_d, alu_co_left, alu_co_right, alu_equ,
    output out_valid, out_res, out_cout, out_zero, out_negzero, out_equ,
    input  out_ready
  );

  modport master (
    output in_valid, in_a, in_b, in_func, in_com, in_cin,
    input  in_ready,
    input  alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left,
    output alu_d, alu_co_left, alu_co_right, alu_equ,
    input  out_valid, out_res, out_cout, out_zero, out_negzero, out_equ,
    output out_ready
  );
endinterface

// File: rtl/xalu_nibble_seq.sv
// Nibble-serial word sequencer in front of a combinational 4-bit ALU slice:
// walks one word op through the slice a nibble per cycle and returns word result + flags.
module xalu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  xalu_nibble_seq_if.slave  bus
);
  localparam int         W     = 4 * NIBBLES;
  localparam int         CW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [2:0] F_SHR = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_a, r_b, r_res, w_res_nxt;
  logic [2:0]    r_func;
  logic          r_com, r_cin, r_carry, r_equ, r_zero, r_negz;
  logic [CW-1:0] r_cnt, w_idx;
  logic          w_shr, w_first, w_last, w_ci;
  logic [NIBBLES-1:0] w_sel;
  logic [3:0]    w_nib_a, w_nib_b;

  assign w_shr   = (r_func == F_SHR);
  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == CW'(NIBBLES - 1));
  // SHR walks MSB-first so the shift-in enters at the top nibble
  assign w_idx   = w_shr ? (CW'(NIBBLES - 1) - r_cnt) : r_cnt;
  assign w_ci    = w_first ? r_cin : r_carry;

  for (genvar g = 0; g < NIBBLES; g++) begin : g_nib
    assign w_sel[g]             = (w_idx == CW'(g));
    assign w_res_nxt[4*g +: 4]  = w_sel[g] ? bus.alu_d : r_res[4*g +: 4];
  end

  always_comb begin
    w_nib_a = '0;
    w_nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (w_sel[i]) begin
        w_nib_a = r_a[4*i +: 4];
        w_nib_b = r_b[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    bus.in_ready     = 1'b0;
    bus.out_valid    = 1'b0;
    bus.alu_a        = '0;
    bus.alu_b        = '0;
    bus.alu_f        = '0;
    bus.alu_com      = 1'b0;
    bus.alu_ci_right = 1'b0;
    bus.alu_ci_left  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        bus.alu_a   = w_nib_a;
        bus.alu_b   = w_nib_b;
        bus.alu_f   = r_func;
        bus.alu_com = r_com;
        if (w_shr) bus.alu_ci_left  = w_ci;
        else       bus.alu_ci_right = w_ci;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_func  <= '0;
      r_com   <= 1'b0;
      r_cin   <= 1'b0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_equ   <= 1'b0;
      r_zero  <= 1'b0;
      r_negz  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a    <= bus.in_a;
            r_b    <= bus.in_b;
            r_func <= bus.in_func;
            r_com  <= bus.in_com;
            r_cin  <= bus.in_cin;
            r_res  <= '0;
            r_cnt  <= '0;
            r_equ  <= 1'b1;
          end
        end
        S_RUN: begin
          r_res   <= w_res_nxt;
          r_equ   <= r_equ & bus.alu_equ;
          r_carry <= w_shr ? bus.alu_co_right : bus.alu_co_left;
          r_cnt   <= r_cnt + CW'(1);
          // flags latch from the completed word, so they stay valid through IDLE
          if (w_last) begin
            r_zero <= (w_res_nxt == '0);
            r_negz <= &w_res_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_res     = r_res;
  assign bus.out_cout    = r_carry;
  assign bus.out_zero    = r_zero;
  assign bus.out_negzero = r_negz;
  assign bus.out_equ     = r_equ;
endmodule

// File: tb/tb_xalu_nibble_seq.sv
// Bench for xalu_nibble_seq: behavioural 4-bit slice, directed word ops,
// scoreboard queue filled at issue time and drained by an output monitor.
module tb_xalu_nibble_seq;
  localparam int NIBBLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xalu_nibble_seq_if #(.NIBBLES(NIBBLES)) intf ();

  xalu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  // behavioural slice
  logic [4:0] s_sum;
  logic [3:0] s_raw;
  always_comb begin
    s_sum = {1'b0, intf.alu_a} + {1'b0, intf.alu_b} + {4'b0, intf.alu_ci_right};
    s_raw = '0;
    intf.alu_co_left  = 1'b0;
    intf.alu_co_right = 1'b0;
    case (intf.alu_f)
      3'd0: begin s_raw = s_sum[3:0]; intf.alu_co_left = s_sum[4]; end
      3'd1: s_raw = intf.alu_a & intf.alu_b;
      3'd2: s_raw = intf.alu_a | intf.alu_b;
      3'd3: s_raw = intf.alu_a ^ intf.alu_b;
      3'd4: s_raw = intf.alu_a;
      3'd5: s_raw = intf.alu_b;
      3'd6: begin s_raw = {intf.alu_ci_left, intf.alu_a[3:1]}; intf.alu_co_right = intf.alu_a[0]; end
      default: begin s_raw = {intf.alu_a[2:0], intf.alu_ci_right}; intf.alu_co_left = intf.alu_a[3]; end
    endcase
    intf.alu_d   = intf.alu_com ? ~s_raw : s_raw;
    intf.alu_equ = (intf.alu_a == intf.alu_b);
  end

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        zero;
    logic        negz;
    logic        equ;
    string       name;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [3:0] alu_log[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: logs slice A nibbles during RUN, checks every consumed result
  always @(negedge clk) begin
    if (!rst) begin
      if (!intf.in_ready && !intf.out_valid) alu_log.push_back(intf.alu_a);
      if (intf.out_valid && intf.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got res %0h with no expected entry", intf.out_res);
        end else begin
          mon_e = sb_q.pop_front();
          chk({mon_e.name, "_res"},  {16'h0, intf.out_res},     {16'h0, mon_e.res});
          chk({mon_e.name, "_cout"}, {31'h0, intf.out_cout},    {31'h0, mon_e.cout});
          chk({mon_e.name, "_zero"}, {31'h0, intf.out_zero},    {31'h0, mon_e.zero});
          chk({mon_e.name, "_negz"}, {31'h0, intf.out_negzero}, {31'h0, mon_e.negz});
          chk({mon_e.name, "_equ"},  {31'h0, intf.out_equ},     {31'h0, mon_e.equ});
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] res, input logic cout, input logic zero,
                          input logic negz, input logic equ, input string name);
    exp_t e;
    e.res = res; e.cout = cout; e.zero = zero; e.negz = negz; e.equ = equ; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f,
                       input logic com, input logic cin);
    intf.in_a = a; intf.in_b = b; intf.in_func = f; intf.in_com = com; intf.in_cin = cin;
    intf.in_valid = 1'b1;
  endtask

  // call between posedge+2 and the next negedge; returns at posedge+2 (consume)
  // or at the negedge where out_valid first shows (no consume)
  task automatic issue(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] f, input logic com, input logic cin,
                       input logic [15:0] res, input logic cout, input logic zero,
                       input logic negz, input logic equ,
                       input bit consume, input bit chk_seq, input logic [15:0] seq);
    bit ok;
    int lat;
    push_exp(res, cout, zero, negz, equ, name);
    alu_log.delete();
    drive(a, b, f, com, cin);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (intf.in_ready) begin ok = 1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL %s_accept: got timeout expected in_ready", name); end
    @(posedge clk); #2;
    intf.in_valid = 1'b0;
    ok = 0; lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (intf.out_valid) begin ok = 1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL %s_done: got timeout expected out_valid", name); end
    else chk({name, "_latency"}, lat, NIBBLES + 1);
    if (consume) begin
      @(posedge clk); #2;
      if (chk_seq) begin
        chk({name, "_seqlen"}, alu_log.size(), NIBBLES);
        if (alu_log.size() == NIBBLES)
          chk({name, "_seq"}, {16'h0, alu_log[0], alu_log[1], alu_log[2], alu_log[3]}, {16'h0, seq});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    intf.in_valid = 1'b0; intf.in_a = '0; intf.in_b = '0; intf.in_func = '0;
    intf.in_com = 1'b0; intf.in_cin = 1'b0; intf.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  {31'h0, intf.in_ready},  1);
    chk("rst_out_valid", {31'h0, intf.out_valid}, 0);
    chk("rst_res",       {16'h0, intf.out_res},   0);
    chk("rst_flags", {28'h0, intf.out_cout, intf.out_zero, intf.out_negzero, intf.out_equ}, 0);

    @(posedge clk); #2;
    //      name        a        b        f     com   cin   res      co    z     n     e     cons seq  seqv
    issue("add",      16'h00FF, 16'h0001, 3'd0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 16'hFF00);
    issue("add_wrap", 16'hFFFF, 16'h0001, 3'd0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 16'h0);
    issue("shl",      16'h8001, 16'h0000, 3'd7, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 16'h1008);
    issue("shr",      16'h8001, 16'h0000, 3'd6, 1'b0, 1'b0, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 16'h8001);
    issue("xor_com",  16'h1234, 16'h1234, 3'd3, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 16'h0);
    issue("and",      16'h0F0F, 16'h00FF, 3'd1, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 16'h0);
    issue("or",       16'hF000, 16'h000F, 3'd2, 1'b0, 1'b0, 16'hF00F, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 16'h0);
    issue("passb",    16'h1111, 16'hABCD, 3'd5, 1'b0, 1'b0, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 16'h0);
    issue("passa",    16'h5A5A, 16'h0000, 3'd4, 1'b0, 1'b0, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 16'h0);
    issue("add_cin",  16'h1234, 16'h1111, 3'd0, 1'b0, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 16'h0);
    issue("add_com",  16'h0001, 16'h0001, 3'd0, 1'b1, 1'b0, 16'hFFFD, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 16'h0);
    issue("shl_ff",   16'hFFFF, 16'h0000, 3'd7, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 16'h0);

    // backpressure: result held while a second request is pending
    intf.out_ready = 1'b0;
    issue("bp_and",   16'hFFFF, 16'h1234, 3'd1, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      drive(16'h7777, 16'h0000, 3'd4, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp_hold_valid", {31'h0, intf.out_valid}, 1);
      chk("bp_hold_res",   {16'h0, intf.out_res},   32'h1234);
      chk("bp_hold_ready", {31'h0, intf.in_ready},  0);
    end
    @(posedge clk); #2;
    intf.out_ready = 1'b1;
    push_exp(16'h7777, 1'b0, 1'b0, 1'b0, 1'b0, "bp_passa");
    @(negedge clk);
    chk("bp_release_ready", {31'h0, intf.in_ready}, 0);
    @(negedge clk);
    chk("bp_idle_ready", {31'h0, intf.in_ready},  1);
    chk("bp_idle_valid", {31'h0, intf.out_valid}, 0);
    @(posedge clk); #2;
    intf.in_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (intf.out_valid) begin ok = 1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL bp_second_done: got timeout expected out_valid"); end
    @(posedge clk); #2;

    // reset two steps into RUN discards the op
    drive(16'h1111, 16'h2222, 3'd0, 1'b0, 1'b0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (intf.in_ready) begin ok = 1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL rstrun_accept: got timeout expected in_ready"); end
    @(posedge clk); #2;
    intf.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rstrun_in_ready",  {31'h0, intf.in_ready},  1);
    chk("rstrun_out_valid", {31'h0, intf.out_valid}, 0);
    chk("rstrun_res",       {16'h0, intf.out_res},   0);
    chk("rstrun_cout",      {31'h0, intf.out_cout},  0);
    chk("rstrun_alu", {16'h0, intf.alu_a, intf.alu_b, intf.alu_f, intf.alu_com,
                       intf.alu_ci_right, intf.alu_ci_left}, 0);
    @(posedge clk); #2;
    issue("post_rst", 16'h0001, 16'h0001, 3'd0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 16'h1000);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
